// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption round engine: one round per SEL+APPLY clock pair.
// The round key comes from an external key_block; SubBytes comes from an external S-box layer.

module aes_mix_col (
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    // {02 03 01 01} circulant; 03*b = xt(b)^b
    assign o_col = {xt(w_a0) ^ xt(w_a1) ^ w_a1 ^ w_a2 ^ w_a3,
                    w_a0 ^ xt(w_a1) ^ xt(w_a2) ^ w_a2 ^ w_a3,
                    w_a0 ^ w_a1 ^ xt(w_a2) ^ xt(w_a3) ^ w_a3,
                    xt(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xt(w_a3)};
endmodule

module aes_round_engine #(
    parameter int NUM_ROUNDS = 10,
    parameter int SEL_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic [SEL_W-1:0] key_select,
    input  logic [127:0]     round_key,
    output logic [127:0]     sb_in,
    input  logic [127:0]     sb_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEL   = 2'd1;
    localparam logic [1:0] S_APPLY = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [3:0] LAST    = 4'(NUM_ROUNDS);

    logic [1:0]       r_fsm;
    logic [3:0]       r_rnd;
    logic [SEL_W-1:0] r_key_sel;
    logic [127:0]     r_state;
    logic [127:0]     w_sr;
    logic [127:0]     w_mc;
    logic [127:0]     w_next;

    // Byte (r,c) lives at [127-8*(r+4c)]; row r takes its byte from column (c+r)%4.
    always_comb begin
        w_sr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[127-8*(r+4*c) -: 8] = sb_out[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_col
            aes_mix_col u_mix (
                .i_col (w_sr[127-32*g -: 32]),
                .o_col (w_mc[127-32*g -: 32])
            );
        end
    endgenerate

    always_comb begin
        if (r_rnd == 4'd0)
            w_next = r_state ^ round_key;
        else if (r_rnd == LAST)
            w_next = w_sr ^ round_key;
        else
            w_next = w_mc ^ round_key;
    end

    // key_select moves to the next round at the end of APPLY so it is already
    // on the bus for the whole SEL cycle; key_block answers during APPLY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm     <= S_IDLE;
            r_state   <= '0;
            r_rnd     <= '0;
            r_key_sel <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_state   <= in_data;
                        r_rnd     <= '0;
                        r_key_sel <= '0;
                        r_fsm     <= S_SEL;
                    end
                end
                S_SEL: begin
                    r_key_sel <= SEL_W'(r_rnd);
                    r_fsm     <= S_APPLY;
                end
                S_APPLY: begin
                    r_state <= w_next;
                    if (r_rnd == LAST) begin
                        r_fsm <= S_DONE;
                    end else begin
                        r_rnd     <= r_rnd + 4'd1;
                        r_key_sel <= SEL_W'(r_rnd + 4'd1);
                        r_fsm     <= S_SEL;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        r_fsm <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_fsm == S_IDLE) && !rst;
    assign out_valid  = (r_fsm == S_DONE);
    assign out_data   = r_state;
    assign sb_in      = r_state;
    assign key_select = r_key_sel;
endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: models key_block and the S-box layer, checks against a
// byte-matrix AES-128 reference built from GF(2^8) arithmetic.

module tb_aes_round_engine;
    typedef logic [10:0][127:0] rks_t;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
        bit           trace;
        int           hold;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [3:0]   key_select;
    logic [127:0] round_key = '0;
    logic [127:0] sb_in;
    logic [127:0] sb_out;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;

    logic [127:0] in_key = '0;
    rks_t         active_rk = '0;
    logic [7:0]   sbox [256];
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    aes_round_engine #(.NUM_ROUNDS(10), .SEL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .key_select (key_select),
        .round_key  (round_key),
        .sb_in      (sb_in),
        .sb_out     (sb_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic rks_t expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rks_t        rk;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] res;
        rks_t         rk;
        rk = expand(key);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127-8*(r+4*c) -: 8] ^ rk[0][127-8*(r+4*c) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = sbox[s[r][(c+r)%4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) begin
                    if (rd < 10)
                        s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                  ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
                    else
                        s[r][c] = t[r][c];
                    s[r][c] = s[r][c] ^ rk[rd][127-8*(r+4*c) -: 8];
                end
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(r+4*c) -: 8] = s[r][c];
        return res;
    endfunction

    // key_block stand-in: latches the key with the block, answers key_select one cycle later.
    always @(posedge clk) begin
        if (in_valid && in_ready) active_rk <= expand(in_key);
        round_key <= (key_select <= 4'd10) ? active_rk[key_select] : '0;
    end

    always_comb begin
        sb_out = '0;
        for (int i = 0; i < 16; i++) sb_out[8*i +: 8] = sbox[sb_in[8*i +: 8]];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_accept(input logic [127:0] key, input logic [127:0] pt, output bit ok);
        int waitc;
        waitc = 0;
        in_key = key;
        in_data = pt;
        in_valid = 1'b1;
        while (!in_ready && waitc < 60) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("accept_ready", in_ready, 1);
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = ~pt;
    endtask

    task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] exp, input bit trace, input int hold);
        bit ok;
        do_accept(key, pt, ok);
        if (!ok) return;
        for (int e = 0; e <= 22; e++) begin
            if (e > 0) begin @(posedge clk); #1; end
            if (trace && e <= 21) check("key_select_trace", key_select, e / 2);
            check("out_valid_timing", out_valid, e == 22);
        end
        check("out_data", out_data, exp);
        check("sb_in_tracks_state", sb_in, exp);
        for (int h = 0; h < hold; h++) begin
            in_valid = (h == 4);
            in_data = pt ^ 128'h1;
            @(posedge clk); #1;
            check("done_hold_valid", out_valid, 1);
            check("done_hold_data", out_data, exp);
            check("done_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("idle_ready", in_ready, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         tbl [3];
        logic [127:0] k, p;
        logic [7:0]   inv;
        bit           ok;
        int           npulse, gap;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end

        tbl[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                   128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 0};
        tbl[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                   128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 10};
        tbl[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                   128'h3925841d02dc09fbdc118597196a0b32, 1'b1, 2};

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_key_select", key_select, 0);
        check("rst_state", out_data, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", in_ready, 1);

        for (int i = 0; i < 3; i++)
            run_block(tbl[i].key, tbl[i].pt, tbl[i].ct, tbl[i].trace, tbl[i].hold);

        // Abort during APPLY of round 5 (11 edges after accept), then recover.
        do_accept(tbl[0].key, tbl[0].pt, ok);
        repeat (11) @(posedge clk);
        #1;
        check("mid_key_select", key_select, 5);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_key_select", key_select, 0);
        rst = 1'b0;
        #1;
        check("abort_ready_after", in_ready, 1);
        run_block(tbl[1].key, tbl[1].pt, tbl[1].ct, 1'b1, 0);

        for (int i = 0; i < 6; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            run_block(k, p, aes_enc(k, p), 1'b0, int'($urandom_range(0, 3)));
        end

        // Back-to-back: out_ready and in_valid held high across two blocks.
        out_ready = 1'b1;
        do_accept(tbl[0].key, tbl[0].pt, ok);
        in_valid = 1'b1;
        in_key = tbl[1].key;
        in_data = tbl[1].pt;
        npulse = 0;
        gap = 0;
        for (int c = 0; c < 80 && npulse < 2; c++) begin
            if (out_valid) begin
                check("b2b_data", out_data, (npulse == 0) ? tbl[0].ct : tbl[1].ct);
                if (npulse == 1) check("b2b_gap", gap, 23);
                npulse++;
            end else if (npulse == 1) begin
                gap++;
            end
            @(posedge clk); #1;
        end
        check("b2b_pulses", npulse, 2);
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
